// File: rtl/lpc_reg_bank.sv
// LPC-side register bank: per-bit writable / write-1-to-clear masks, registered
// reads, a sticky hardware-status register, a one-shot strap capture after reset,
// and a two-key lock that guards the registers selected by PROT_MASK.
module lpc_reg_bank #(
  parameter int                           NUM_REGS   = 32,
  parameter int                           ADDR_W     = 8,
  parameter int                           DATA_W     = 8,
  parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL    = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]   WR_MASK    = '1,
  parameter logic [NUM_REGS*DATA_W-1:0]   W1C_MASK   = '0,
  parameter logic [NUM_REGS-1:0]          PROT_MASK  = '0,
  parameter int                           STRAP_ADDR = 4,
  parameter int                           HWSTS_ADDR = 30,
  parameter int                           LOCK_ADDR  = 31,
  parameter logic [DATA_W-1:0]            KEY0       = 'h5A,
  parameter logic [DATA_W-1:0]            KEY1       = 'hA5
) (
  input  logic                         LpcClock,
  input  logic                         PciReset,
  input  logic [ADDR_W-1:0]            Addr,
  input  logic                         Wr,
  input  logic [DATA_W-1:0]            DataWr,
  input  logic                         Rd,
  output logic [DATA_W-1:0]            RdData,
  output logic                         RdValid,
  output logic                         WrError,
  input  logic [DATA_W-1:0]            HwEvent,
  input  logic [DATA_W-1:0]            StrapIn,
  output logic                         Locked,
  output logic [NUM_REGS*DATA_W-1:0]   DataReg
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_KEY_WAIT = 2'd1,
    ST_UNLOCKED = 2'd2
  } lock_state_t;

  localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

  lock_state_t                 state_reg, state_next;
  logic                        locked_reg;
  logic                        strap_done_reg;
  logic [NUM_REGS-1:0]         hit;
  logic                        in_range, lock_hit, prot_hit, wr_ok, wr_reject;
  logic [NUM_REGS*DATA_W-1:0]  data_flat;
  logic [DATA_W-1:0]           rd_mux;
  logic [DATA_W-1:0]           rd_data_reg;
  logic                        rd_valid_reg, wr_error_reg;

  // Address decode; one-hot hit avoids indexing masks with an out-of-range address.
  assign in_range  = {1'b0, Addr} < NUM_REGS_A;
  assign lock_hit  = (Addr == ADDR_W'(LOCK_ADDR));
  assign prot_hit  = |(hit & PROT_MASK);
  assign wr_ok     = Wr && in_range && !lock_hit && (!prot_hit || state_reg == ST_UNLOCKED);
  assign wr_reject = Wr && !lock_hit && !wr_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      assign hit[gi] = (Addr == ADDR_W'(gi));
      if (gi == LOCK_ADDR) begin : g_lock
        // The lock slot mirrors the FSM state instead of holding array data.
        assign data_flat[gi*DATA_W +: DATA_W] = {{(DATA_W-2){1'b0}}, state_reg};
      end else begin : g_reg
        localparam logic [DATA_W-1:0] M  = WR_MASK[gi*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] C  = W1C_MASK[gi*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] RV = (gi == STRAP_ADDR) ? {DATA_W{1'b0}}
                                                              : RST_VAL[gi*DATA_W +: DATA_W];
        logic [DATA_W-1:0] value_reg, value_next;

        // Host write, then sticky events, then strap capture (highest priority).
        always_comb begin
          value_next = value_reg;
          if (wr_ok && hit[gi])
            value_next = (value_reg & ~M) | (DataWr & M & ~C) | (value_reg & C & ~DataWr);
          if (gi == HWSTS_ADDR)
            value_next = value_next | HwEvent;
          if (gi == STRAP_ADDR && !strap_done_reg)
            value_next = StrapIn;
        end

        // Register storage.
        always_ff @(posedge LpcClock or posedge PciReset) begin
          if (PciReset) value_reg <= RV;
          else          value_reg <= value_next;
        end

        assign data_flat[gi*DATA_W +: DATA_W] = value_reg;
      end
    end
  endgenerate

  // Read mux: unmapped addresses return all ones.
  always_comb begin
    rd_mux = '1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit[i]) rd_mux = data_flat[i*DATA_W +: DATA_W];
    end
  end

  // Lock FSM next state: only lock-register writes advance it; any other write aborts KEY_WAIT.
  always_comb begin
    state_next = state_reg;
    if (Wr && lock_hit) begin
      case (state_reg)
        ST_LOCKED:   state_next = (DataWr == KEY0) ? ST_KEY_WAIT : ST_LOCKED;
        ST_KEY_WAIT: state_next = (DataWr == KEY1) ? ST_UNLOCKED : ST_LOCKED;
        default:     state_next = ST_LOCKED;
      endcase
    end else if (Wr && state_reg == ST_KEY_WAIT) begin
      state_next = ST_LOCKED;
    end
  end

  // Lock FSM state register and registered Locked flag.
  always_ff @(posedge LpcClock or posedge PciReset) begin
    if (PciReset) begin
      state_reg  <= ST_LOCKED;
      locked_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      locked_reg <= (state_next != ST_UNLOCKED);
    end
  end

  // Strap capture happens exactly once per reset.
  always_ff @(posedge LpcClock or posedge PciReset) begin
    if (PciReset) strap_done_reg <= 1'b0;
    else          strap_done_reg <= 1'b1;
  end

  // Registered read data / strobes; RdData holds between reads.
  always_ff @(posedge LpcClock or posedge PciReset) begin
    if (PciReset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      wr_error_reg <= 1'b0;
    end else begin
      rd_valid_reg <= Rd;
      wr_error_reg <= wr_reject;
      if (Rd) rd_data_reg <= rd_mux;
    end
  end

  assign RdData  = rd_data_reg;
  assign RdValid = rd_valid_reg;
  assign WrError = wr_error_reg;
  assign Locked  = locked_reg;
  assign DataReg = data_flat;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// Self-checking bench for lpc_reg_bank: a behavioural model predicts register
// contents; expected read data is queued at issue and compared when RdValid fires.
module tb_lpc_reg_bank;

  localparam logic [255:0] P_RST  = (256'hC3) | (256'h11 << 8) | (256'h44 << 16) | (256'h5E << 32);
  localparam logic [255:0] P_WRM  = ~(256'h80 << 72);
  localparam logic [255:0] P_W1C  = (256'hFF << 240);
  localparam logic [31:0]  P_PROT = 32'h0000_0004;

  logic         LpcClock = 1'b0;
  logic         PciReset;
  logic [7:0]   Addr;
  logic         Wr;
  logic [7:0]   DataWr;
  logic         Rd;
  logic [7:0]   RdData;
  logic         RdValid;
  logic         WrError;
  logic [7:0]   HwEvent;
  logic [7:0]   StrapIn;
  logic         Locked;
  logic [255:0] DataReg;

  lpc_reg_bank #(
    .NUM_REGS(32), .ADDR_W(8), .DATA_W(8),
    .RST_VAL(P_RST), .WR_MASK(P_WRM), .W1C_MASK(P_W1C), .PROT_MASK(P_PROT)
  ) dut (
    .LpcClock(LpcClock), .PciReset(PciReset), .Addr(Addr), .Wr(Wr), .DataWr(DataWr),
    .Rd(Rd), .RdData(RdData), .RdValid(RdValid), .WrError(WrError), .HwEvent(HwEvent),
    .StrapIn(StrapIn), .Locked(Locked), .DataReg(DataReg)
  );

  always #15 LpcClock = ~LpcClock;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_regs [32];
  logic [1:0] m_state;
  bit         m_strap_done;
  logic [7:0] rd_q [$];
  logic [7:0] sb_exp;

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 32; i++) f[i*8 +: 8] = (i == 31) ? {6'b0, m_state} : m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 4) ? 8'h00 : P_RST[i*8 +: 8];
    m_state = 2'd0;
    m_strap_done = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict its effect, queue any expected read.
  task automatic access(input logic wr, input logic rd, input int addr,
                        input logic [7:0] data, input logic [7:0] hw);
    logic [7:0] old, nv;
    bit acc;
    if (rd) begin
      if (addr >= 32)      rd_q.push_back(8'hFF);
      else if (addr == 31) rd_q.push_back({6'b0, m_state});
      else                 rd_q.push_back(m_regs[addr]);
    end
    if (wr) begin
      if (addr == 31) begin
        case (m_state)
          2'd0:    m_state = (data == 8'h5A) ? 2'd1 : 2'd0;
          2'd1:    m_state = (data == 8'hA5) ? 2'd2 : 2'd0;
          default: m_state = 2'd0;
        endcase
      end else begin
        acc = (addr < 32) && !(P_PROT[addr % 32] && m_state != 2'd2);
        if (acc) begin
          old = m_regs[addr];
          for (int b = 0; b < 8; b++) begin
            if (!P_WRM[addr*8 + b])     nv[b] = old[b];
            else if (P_W1C[addr*8 + b]) nv[b] = data[b] ? 1'b0 : old[b];
            else                        nv[b] = data[b];
          end
          m_regs[addr] = nv;
        end
        if (m_state == 2'd1) m_state = 2'd0;
      end
    end
    m_regs[30] = m_regs[30] | hw;
    if (!m_strap_done) begin
      m_regs[4] = StrapIn;
      m_strap_done = 1'b1;
    end
    Wr = wr; Rd = rd; Addr = addr[7:0]; DataWr = data; HwEvent = hw;
    @(posedge LpcClock); #2;
    Wr = 1'b0; Rd = 1'b0; HwEvent = 8'h00;
  endtask

  // Scoreboard: every read must return exactly one cycle after issue.
  always begin
    @(posedge LpcClock); #1;
    if (!PciReset && (RdValid || rd_q.size() != 0)) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: RdValid=%b RdData=%h with no read pending", RdValid, RdData);
      end else begin
        sb_exp = rd_q.pop_front();
        if (!RdValid || RdData !== sb_exp) begin
          errors++;
          $display("FAIL rd_data: got valid=%b data=%h expected valid=1 data=%h", RdValid, RdData, sb_exp);
        end else
          $display("read ok: addr=%0d data=%h", Addr, RdData);
      end
    end
  end

  task automatic test_reset();
    PciReset = 1'b1; Wr = 0; Rd = 0; Addr = 0; DataWr = 0; HwEvent = 0; StrapIn = 8'h03;
    repeat (2) @(posedge LpcClock);
    #2;
    model_reset();
    checks += 5;
    if (RdValid !== 1'b0) begin errors++; $display("FAIL reset_rdvalid: got %b expected 0", RdValid); end
    if (WrError !== 1'b0) begin errors++; $display("FAIL reset_wrerror: got %b expected 0", WrError); end
    if (Locked !== 1'b1)  begin errors++; $display("FAIL reset_locked: got %b expected 1", Locked); end
    if (RdData !== 8'h00) begin errors++; $display("FAIL reset_rddata: got %h expected 00", RdData); end
    if (DataReg !== model_flat()) begin errors++; $display("FAIL reset_regs: got %h expected %h", DataReg, model_flat()); end
    $display("reset: Locked=%b reg0=%h reg4=%h", Locked, DataReg[7:0], DataReg[39:32]);
    PciReset = 1'b0;
  endtask

  task automatic test_strap();
    // Host write on the capture edge loses; the read returns the pre-capture value.
    access(1, 1, 4, 8'h99, 8'h00);
    checks++;
    if (DataReg[39:32] !== 8'h03) begin errors++; $display("FAIL strap_capture: got %h expected 03", DataReg[39:32]); end
    StrapIn = 8'h77;
    access(0, 1, 4, 8'h00, 8'h00);
    access(0, 0, 0, 8'h00, 8'h00);
    checks++;
    if (DataReg[39:32] !== 8'h03) begin errors++; $display("FAIL strap_once: got %h expected 03", DataReg[39:32]); end
    $display("strap: reg4=%h", DataReg[39:32]);
  endtask

  task automatic test_write_mask();
    access(1, 0, 9, 8'h33, 8'h00);
    access(1, 0, 9, 8'hFF, 8'h00);
    access(0, 1, 9, 8'h00, 8'h00);
    checks++;
    if (DataReg[79:72] !== 8'h7F) begin errors++; $display("FAIL wr_mask: got %h expected 7f", DataReg[79:72]); end
    access(0, 0, 0, 8'h00, 8'h00);
    checks += 2;
    if (RdValid !== 1'b0) begin errors++; $display("FAIL rdvalid_pulse: got %b expected 0", RdValid); end
    if (RdData !== 8'h7F) begin errors++; $display("FAIL rddata_hold: got %h expected 7f", RdData); end
    $display("write_mask: reg9=%h", DataReg[79:72]);
  endtask

  task automatic test_protect();
    access(1, 0, 2, 8'h12, 8'h00);
    checks += 2;
    if (WrError !== 1'b1) begin errors++; $display("FAIL prot_wrerror: got %b expected 1", WrError); end
    if (DataReg[23:16] !== 8'h44) begin errors++; $display("FAIL prot_unchanged: got %h expected 44", DataReg[23:16]); end
    access(1, 0, 31, 8'h5A, 8'h00);
    checks += 2;
    if (WrError !== 1'b0) begin errors++; $display("FAIL wrerror_pulse: got %b expected 0", WrError); end
    if (Locked !== 1'b1) begin errors++; $display("FAIL keywait_locked: got %b expected 1", Locked); end
    access(1, 0, 31, 8'hA5, 8'h00);
    checks++;
    if (Locked !== 1'b0) begin errors++; $display("FAIL unlock: got %b expected 0", Locked); end
    access(1, 0, 2, 8'h12, 8'h00);
    checks++;
    if (WrError !== 1'b0) begin errors++; $display("FAIL unlocked_write: got WrError=%b expected 0", WrError); end
    access(0, 1, 2, 8'h00, 8'h00);
    access(0, 1, 31, 8'h00, 8'h00);
    access(1, 0, 31, 8'h00, 8'h00);
    checks += 2;
    if (Locked !== 1'b1) begin errors++; $display("FAIL relock: got %b expected 1", Locked); end
    if (DataReg !== model_flat()) begin errors++; $display("FAIL prot_regs: got %h expected %h", DataReg, model_flat()); end
    $display("protect: reg2=%h Locked=%b", DataReg[23:16], Locked);
  endtask

  task automatic test_key_abort();
    access(1, 0, 31, 8'h5A, 8'h00);
    access(1, 0, 1, 8'h55, 8'h00);
    access(1, 0, 31, 8'hA5, 8'h00);
    checks += 2;
    if (Locked !== 1'b1) begin errors++; $display("FAIL key_abort_locked: got %b expected 1", Locked); end
    if (DataReg[255:248] !== 8'h00) begin errors++; $display("FAIL key_abort_state: got %h expected 00", DataReg[255:248]); end
    access(0, 1, 31, 8'h00, 8'h00);
    $display("key_abort: Locked=%b reg1=%h", Locked, DataReg[15:8]);
  endtask

  task automatic test_hwsts();
    access(0, 0, 0, 8'h00, 8'h01);
    checks++;
    if (DataReg[240] !== 1'b1) begin errors++; $display("FAIL hw_set: got %b expected 1", DataReg[240]); end
    access(1, 0, 30, 8'h01, 8'h01);
    checks++;
    if (DataReg[240] !== 1'b1) begin errors++; $display("FAIL hw_set_wins: got %b expected 1", DataReg[240]); end
    access(1, 0, 30, 8'h01, 8'h00);
    checks++;
    if (DataReg[240] !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b expected 0", DataReg[240]); end
    access(0, 0, 0, 8'h00, 8'h0C);
    access(1, 0, 30, 8'h04, 8'h00);
    access(0, 1, 30, 8'h00, 8'h00);
    checks++;
    if (DataReg[247:240] !== 8'h08) begin errors++; $display("FAIL w1c_partial: got %h expected 08", DataReg[247:240]); end
    $display("hwsts: reg30=%h", DataReg[247:240]);
  endtask

  task automatic test_back_to_back();
    access(1, 0, 40, 8'h12, 8'h00);
    checks += 2;
    if (WrError !== 1'b1) begin errors++; $display("FAIL range_wrerror: got %b expected 1", WrError); end
    if (DataReg !== model_flat()) begin errors++; $display("FAIL range_regs: got %h expected %h", DataReg, model_flat()); end
    access(0, 1, 200, 8'h00, 8'h00);
    access(1, 0, 5, 8'hAB, 8'h00);
    access(1, 1, 5, 8'hCD, 8'h00);
    access(0, 1, 5, 8'h00, 8'h00);
    access(0, 1, 0, 8'h00, 8'h00);
    access(0, 1, 1, 8'h00, 8'h00);
    $display("back_to_back: reg5=%h", DataReg[47:40]);
  endtask

  task automatic test_reset_mid();
    access(1, 0, 31, 8'h5A, 8'h00);
    access(0, 1, 3, 8'h00, 8'h00);
    #5;
    PciReset = 1'b1;
    #1;
    model_reset();
    checks += 4;
    if (RdValid !== 1'b0) begin errors++; $display("FAIL mid_rdvalid: got %b expected 0", RdValid); end
    if (RdData !== 8'h00) begin errors++; $display("FAIL mid_rddata: got %h expected 00", RdData); end
    if (Locked !== 1'b1)  begin errors++; $display("FAIL mid_locked: got %b expected 1", Locked); end
    if (DataReg !== model_flat()) begin errors++; $display("FAIL mid_regs: got %h expected %h", DataReg, model_flat()); end
    repeat (2) @(posedge LpcClock);
    #2;
    PciReset = 1'b0;
    access(1, 0, 31, 8'hA5, 8'h00);
    checks += 2;
    if (Locked !== 1'b1) begin errors++; $display("FAIL mid_unlock_lost: got %b expected 1", Locked); end
    if (DataReg !== model_flat()) begin errors++; $display("FAIL mid_recapture: got %h expected %h", DataReg, model_flat()); end
    $display("reset_mid: Locked=%b reg4=%h", Locked, DataReg[39:32]);
  endtask

  initial begin
    test_reset();
    test_strap();
    test_write_mask();
    test_protect();
    test_key_abort();
    test_hwsts();
    test_back_to_back();
    test_reset_mid();
    access(0, 0, 0, 8'h00, 8'h00);
    checks++;
    if (rd_q.size() != 0) begin errors++; $display("FAIL rd_pending: got %0d outstanding expected 0", rd_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
